// File: rtl/decode_hazard_sequencer_pkg.sv
// Shared types and constants for the decode hazard sequencer.
// Forwarding select encodings, the double-word FSM state type and default opcodes.
package decode_hazard_sequencer_pkg;

    typedef enum logic [1:0] {
        FW_RF  = 2'd0,
        FW_ALU = 2'd1,
        FW_MEM = 2'd2,
        FW_WB  = 2'd3
    } fw_sel_e;

    typedef enum logic {
        NORMAL    = 1'b0,
        DW_SECOND = 1'b1
    } dw_state_e;

    localparam logic [5:0] LDW_OP_DEFAULT = 6'h11;
    localparam logic [5:0] SDW_OP_DEFAULT = 6'h12;

    // r0 is hardwired to zero, so it never matches a producer.
    function automatic logic src_match(input logic [3:0] src, input logic used,
                                       input logic wr, input logic [3:0] rd);
        return used && wr && (src != 4'd0) && (rd == src);
    endfunction

endpackage

// File: rtl/decode_hazard_sequencer_fwd_select.sv
// Per-source priority comparator: forwarding select and hazard flag for one operand.
// With HAZ_FWD_EN undefined the select is tied to FW_RF and any pending producer stalls.
module fwd_select
    import decode_hazard_sequencer_pkg::*;
(
    input  logic [3:0] src_i,
    input  logic       src_used_i,
    input  logic [3:0] ex_rd_i,
    input  logic       ex_reg_w_i,
    input  logic       ex_mem_r_i,
    input  logic [3:0] mem_rd_i,
    input  logic       mem_reg_w_i,
    input  logic [3:0] wb_rd_i,
    input  logic       wb_reg_w_i,
    output fw_sel_e    sel_o,
    output logic       lu_o
);

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    assign ex_hit  = src_match(src_i, src_used_i, ex_reg_w_i, ex_rd_i);
    assign mem_hit = src_match(src_i, src_used_i, mem_reg_w_i, mem_rd_i);
    assign wb_hit  = src_match(src_i, src_used_i, wb_reg_w_i, wb_rd_i);

`ifdef HAZ_FWD_EN
    always_comb begin
        sel_o = FW_RF;
        if (ex_hit && !ex_mem_r_i) begin
            sel_o = FW_ALU;
        end else if (mem_hit) begin
            sel_o = FW_MEM;
        end else if (wb_hit) begin
            sel_o = FW_WB;
        end
    end

    assign lu_o = ex_hit && ex_mem_r_i;
`else
    logic unused_ex_mem_r;

    assign unused_ex_mem_r = ex_mem_r_i;
    assign sel_o           = FW_RF;
    // Without bypass paths the operand is only valid once the producer has left WB.
    assign lu_o            = ex_hit || mem_hit || wb_hit;
`endif

endmodule

// File: rtl/decode_hazard_sequencer.sv
// Decode-stage sequencer: operand forwarding, load-use stall, LDW/SDW split, stall counter.
// Optional macro HAZ_FWD_EN enables the EX/MEM/WB bypass selects.
module decode_hazard_sequencer
    import decode_hazard_sequencer_pkg::*;
#(
    parameter logic [5:0]  LDW_OP = LDW_OP_DEFAULT,
    parameter logic [5:0]  SDW_OP = SDW_OP_DEFAULT,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [5:0]       op_code,
    input  logic [3:0]       rs,
    input  logic [3:0]       rb,
    input  logic             src_a_used,
    input  logic             src_b_used,
    input  logic [3:0]       ex_rd,
    input  logic [3:0]       mem_rd,
    input  logic [3:0]       wb_rd,
    input  logic             ex_reg_w,
    input  logic             mem_reg_w,
    input  logic             wb_reg_w,
    input  logic             ex_mem_r,
    output logic [1:0]       fwa,
    output logic [1:0]       fwb,
    output logic             pc_hold,
    output logic             bubble,
    output logic             add_rd,
    output logic             add_imm,
    output logic             dw_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    dw_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    fw_sel_e          sel_a, sel_b;
    logic             lu_a, lu_b;
    logic             lu;
    logic             is_dw;
    logic             hold_raw, bubble_raw;

    fwd_select u_fwd_a (
        .src_i       (rs),
        .src_used_i  (src_a_used),
        .ex_rd_i     (ex_rd),
        .ex_reg_w_i  (ex_reg_w),
        .ex_mem_r_i  (ex_mem_r),
        .mem_rd_i    (mem_rd),
        .mem_reg_w_i (mem_reg_w),
        .wb_rd_i     (wb_rd),
        .wb_reg_w_i  (wb_reg_w),
        .sel_o       (sel_a),
        .lu_o        (lu_a)
    );

    fwd_select u_fwd_b (
        .src_i       (rb),
        .src_used_i  (src_b_used),
        .ex_rd_i     (ex_rd),
        .ex_reg_w_i  (ex_reg_w),
        .ex_mem_r_i  (ex_mem_r),
        .mem_rd_i    (mem_rd),
        .mem_reg_w_i (mem_reg_w),
        .wb_rd_i     (wb_rd),
        .wb_reg_w_i  (wb_reg_w),
        .sel_o       (sel_b),
        .lu_o        (lu_b)
    );

    assign lu    = lu_a || lu_b;
    assign is_dw = (op_code == LDW_OP) || (op_code == SDW_OP);

    always_comb begin
        state_d    = state_q;
        hold_raw   = 1'b0;
        bubble_raw = 1'b0;
        unique case (state_q)
            NORMAL: begin
                if (lu) begin
                    hold_raw   = 1'b1;
                    bubble_raw = 1'b1;
                end else if (is_dw) begin
                    // First half issues; hold decode so the second half sees the same word.
                    hold_raw = 1'b1;
                    state_d  = DW_SECOND;
                end
            end
            DW_SECOND: begin
                if (lu) begin
                    hold_raw   = 1'b1;
                    bubble_raw = 1'b1;
                end else begin
                    state_d = NORMAL;
                end
            end
            default: state_d = NORMAL;
        endcase
    end

    // Combinational outputs are forced low while reset is asserted.
    assign fwa     = clear ? sel_a : FW_RF;
    assign fwb     = clear ? sel_b : FW_RF;
    assign pc_hold = clear && hold_raw;
    assign bubble  = clear && bubble_raw;

    // Moore decode only, so rb (muxed by add_rd) cannot loop back combinationally.
    assign dw_busy = (state_q == DW_SECOND);
    assign add_rd  = dw_busy;
    assign add_imm = dw_busy;

    always_comb begin
        cnt_d = cnt_q;
        if (bubble && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = cnt_q;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= NORMAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_decode_hazard_sequencer.sv
// Directed bench for decode_hazard_sequencer: table of single-cycle vectors plus
// hand-written multi-cycle sequences (load-use, LDW/SDW split, reset, saturation).
module tb_decode_hazard_sequencer;

`ifdef HAZ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [5:0] LDW = 6'h11;
    localparam logic [5:0] SDW = 6'h12;

    logic        clk = 1'b0;
    logic        clear;
    logic [5:0]  op_code;
    logic [3:0]  rs, rb, ex_rd, mem_rd, wb_rd;
    logic        src_a_used, src_b_used, ex_reg_w, mem_reg_w, wb_reg_w, ex_mem_r;
    logic [1:0]  fwa, fwb, s_fwa, s_fwb;
    logic        pc_hold, bubble, add_rd, add_imm, dw_busy;
    logic        s_hold, s_bubble, s_add_rd, s_add_imm, s_busy;
    logic [15:0] stall_cnt;
    logic [3:0]  s_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    decode_hazard_sequencer #(.CNT_W(16)) dut (
        .clk(clk), .clear(clear), .op_code(op_code), .rs(rs), .rb(rb),
        .src_a_used(src_a_used), .src_b_used(src_b_used),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_reg_w(ex_reg_w), .mem_reg_w(mem_reg_w), .wb_reg_w(wb_reg_w),
        .ex_mem_r(ex_mem_r), .fwa(fwa), .fwb(fwb), .pc_hold(pc_hold),
        .bubble(bubble), .add_rd(add_rd), .add_imm(add_imm), .dw_busy(dw_busy),
        .stall_cnt(stall_cnt)
    );

    decode_hazard_sequencer #(.CNT_W(4)) dut_sat (
        .clk(clk), .clear(clear), .op_code(op_code), .rs(rs), .rb(rb),
        .src_a_used(src_a_used), .src_b_used(src_b_used),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_reg_w(ex_reg_w), .mem_reg_w(mem_reg_w), .wb_reg_w(wb_reg_w),
        .ex_mem_r(ex_mem_r), .fwa(s_fwa), .fwb(s_fwb), .pc_hold(s_hold),
        .bubble(s_bubble), .add_rd(s_add_rd), .add_imm(s_add_imm), .dw_busy(s_busy),
        .stall_cnt(s_cnt)
    );

    typedef struct {
        logic [3:0] rs, rb;
        logic       au, bu;
        logic [3:0] exr, memr, wbr;
        logic       exw, memw, wbw, exl;
        logic [1:0] fa, fb;  // selects with forwarding enabled
        logic       luf, lun;  // stall with / without forwarding
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        op_code = 6'h00; rs = 4'd0; rb = 4'd0; src_a_used = 1'b0; src_b_used = 1'b0;
        ex_rd = 4'd0; mem_rd = 4'd0; wb_rd = 4'd0;
        ex_reg_w = 1'b0; mem_reg_w = 1'b0; wb_reg_w = 1'b0; ex_mem_r = 1'b0;
    endtask

    task automatic set_load_use(input logic [3:0] r);
        ex_mem_r = 1'b1; ex_reg_w = 1'b1; ex_rd = r; rb = r; src_b_used = 1'b1;
    endtask

    task automatic check_ctrl(input string name, input logic hold, input logic bub,
                              input logic busy);
        check({name, ".pc_hold"}, 32'(pc_hold), 32'(hold));
        check({name, ".bubble"}, 32'(bubble), 32'(bub));
        check({name, ".dw_busy"}, 32'(dw_busy), 32'(busy));
        check({name, ".add_rd"}, 32'(add_rd), 32'(busy));
        check({name, ".add_imm"}, 32'(add_imm), 32'(busy));
    endtask

    task automatic count_step(input logic bub);
        step();
        if (bub && exp_cnt < 65535) exp_cnt++;
    endtask

    initial begin
        logic lu;
        int   base;
        int   sat_exp;

        vecs[0]  = '{4'd5, 4'd0, 1, 0, 4'd5, 4'd5, 4'd5, 1, 1, 1, 0, 2'd1, 2'd0, 0, 1};
        vecs[1]  = '{4'd5, 4'd0, 1, 0, 4'd5, 4'd5, 4'd5, 0, 1, 1, 0, 2'd2, 2'd0, 0, 1};
        vecs[2]  = '{4'd5, 4'd0, 1, 0, 4'd5, 4'd5, 4'd5, 0, 0, 1, 0, 2'd3, 2'd0, 0, 1};
        vecs[3]  = '{4'd0, 4'd0, 1, 0, 4'd5, 4'd5, 4'd5, 1, 1, 1, 0, 2'd0, 2'd0, 0, 0};
        vecs[4]  = '{4'd5, 4'd0, 0, 0, 4'd5, 4'd5, 4'd5, 1, 1, 1, 0, 2'd0, 2'd0, 0, 0};
        vecs[5]  = '{4'd0, 4'd9, 0, 1, 4'd0, 4'd9, 4'd0, 0, 1, 0, 0, 2'd0, 2'd2, 0, 1};
        vecs[6]  = '{4'd0, 4'd7, 0, 1, 4'd7, 4'd0, 4'd0, 1, 0, 0, 1, 2'd0, 2'd0, 1, 1};
        vecs[7]  = '{4'd0, 4'd7, 0, 0, 4'd7, 4'd0, 4'd0, 1, 0, 0, 1, 2'd0, 2'd0, 0, 0};
        vecs[8]  = '{4'd0, 4'd7, 0, 1, 4'd7, 4'd0, 4'd0, 0, 0, 0, 1, 2'd0, 2'd0, 0, 0};
        vecs[9]  = '{4'd0, 4'd7, 0, 1, 4'd7, 4'd7, 4'd0, 1, 1, 0, 1, 2'd0, 2'd2, 1, 1};
        vecs[10] = '{4'd3, 4'd3, 1, 1, 4'd3, 4'd0, 4'd3, 1, 0, 1, 0, 2'd1, 2'd1, 0, 1};
        vecs[11] = '{4'd0, 4'd0, 1, 1, 4'd0, 4'd0, 4'd0, 1, 0, 0, 1, 2'd0, 2'd0, 0, 0};
        vecs[12] = '{4'd4, 4'd6, 1, 1, 4'd6, 4'd4, 4'd0, 1, 1, 0, 0, 2'd2, 2'd1, 0, 1};
        vecs[13] = '{4'd1, 4'd2, 1, 1, 4'd3, 4'd4, 4'd5, 1, 1, 1, 1, 2'd0, 2'd0, 0, 0};

        // Reset state
        idle_inputs();
        clear = 1'b0;
        #12;
        check("reset.stall_cnt", 32'(stall_cnt), 32'd0);
        check_ctrl("reset", 1'b0, 1'b0, 1'b0);
        clear = 1'b1;
        step();

        // Single-cycle table in NORMAL
        foreach (vecs[i]) begin
            rs = vecs[i].rs; rb = vecs[i].rb;
            src_a_used = vecs[i].au; src_b_used = vecs[i].bu;
            ex_rd = vecs[i].exr; mem_rd = vecs[i].memr; wb_rd = vecs[i].wbr;
            ex_reg_w = vecs[i].exw; mem_reg_w = vecs[i].memw; wb_reg_w = vecs[i].wbw;
            ex_mem_r = vecs[i].exl;
            lu = FWD ? vecs[i].luf : vecs[i].lun;
            #2;
            check($sformatf("vec%0d.fwa", i), 32'(fwa), FWD ? 32'(vecs[i].fa) : 32'd0);
            check($sformatf("vec%0d.fwb", i), 32'(fwb), FWD ? 32'(vecs[i].fb) : 32'd0);
            check_ctrl($sformatf("vec%0d", i), lu, lu, 1'b0);
            count_step(lu);
            check($sformatf("vec%0d.stall_cnt", i), 32'(stall_cnt), 32'(exp_cnt));
        end

        // Load-use: one bubble, then the load sits in MEM
        idle_inputs();
        set_load_use(4'd7);
        base = exp_cnt;
        #2;
        check_ctrl("lu.c1", 1'b1, 1'b1, 1'b0);
        count_step(1'b1);
        idle_inputs();
        rb = 4'd7; src_b_used = 1'b1; mem_rd = 4'd7; mem_reg_w = 1'b1;
        #2;
        check("lu.c2.fwb", 32'(fwb), FWD ? 32'd2 : 32'd0);
        check_ctrl("lu.c2", !FWD, !FWD, 1'b0);
        check("lu.c2.stall_cnt", 32'(stall_cnt), 32'(base + 1));
        count_step(!FWD);
        idle_inputs();

        // LDW hazard-free: two cycles in decode
        op_code = LDW; rs = 4'd2; src_a_used = 1'b1;
        #2;
        check_ctrl("ldw.c1", 1'b1, 1'b0, 1'b0);
        step();
        check_ctrl("ldw.c2", 1'b0, 1'b0, 1'b1);
        step();
        op_code = 6'h00;
        #2;
        check_ctrl("ldw.c3", 1'b0, 1'b0, 1'b0);
        step();

        // SDW with a load-use on the second half
        op_code = SDW;
        #2;
        check_ctrl("sdw.c1", 1'b1, 1'b0, 1'b0);
        step();
        set_load_use(4'd5);
        #2;
        check_ctrl("sdw.c2", 1'b1, 1'b1, 1'b1);
        count_step(1'b1);
        idle_inputs();
        op_code = SDW;
        #2;
        check_ctrl("sdw.c3", 1'b0, 1'b0, 1'b1);
        check("sdw.stall_cnt", 32'(stall_cnt), 32'(exp_cnt));
        step();
        op_code = 6'h00;
        #2;
        check_ctrl("sdw.c4", 1'b0, 1'b0, 1'b0);
        step();

        // Load-use and LDW together: bubble first, first half next cycle
        op_code = LDW;
        set_load_use(4'd3);
        #2;
        check_ctrl("sim.c1", 1'b1, 1'b1, 1'b0);
        count_step(1'b1);
        idle_inputs();
        op_code = LDW;
        #2;
        check_ctrl("sim.c2", 1'b1, 1'b0, 1'b0);
        step();
        check_ctrl("sim.c3", 1'b0, 1'b0, 1'b1);
        step();
        op_code = 6'h00;
        #2;
        check_ctrl("sim.c4", 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in DW_SECOND with live hazards on the inputs
        op_code = LDW;
        step();
        check("rst.pre.dw_busy", 32'(dw_busy), 32'd1);
        set_load_use(4'd6);
        rs = 4'd8; src_a_used = 1'b1; wb_rd = 4'd8; wb_reg_w = 1'b1;
        #2;
        check("rst.pre.pc_hold", 32'(pc_hold), 32'd1);
        clear = 1'b0;
        #1;
        check("rst.fwa", 32'(fwa), 32'd0);
        check("rst.fwb", 32'(fwb), 32'd0);
        check_ctrl("rst", 1'b0, 1'b0, 1'b0);
        check("rst.stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst.sat_cnt", 32'(s_cnt), 32'd0);
        idle_inputs();
        #3;
        clear = 1'b1;
        exp_cnt = 0;
        step();
        check_ctrl("rst.after", 1'b0, 1'b0, 1'b0);

        // Saturation of the 4-bit counter over 20 bubbles
        set_load_use(4'd7);
        sat_exp = 0;
        for (int n = 0; n < 20; n++) begin
            count_step(1'b1);
            if (sat_exp < 15) sat_exp++;
            if (n == 3 || n == 14 || n == 15 || n == 19) begin
                check($sformatf("sat.n%0d", n), 32'(s_cnt), 32'(sat_exp));
            end
        end
        check("sat.wide_cnt", 32'(stall_cnt), 32'(exp_cnt));
        idle_inputs();
        step();
        check("sat.hold_15", 32'(s_cnt), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
